// File: rtl/period_meter_pkg.sv
// period_meter shared types and sizing helpers.
// State encoding plus accumulator/sample-count sizing.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_SYNC     = 2;
  localparam int DEF_AVG_LOG2 = 2;

  localparam int ACC_W = DEF_CNT_W + DEF_AVG_LOG2;
  localparam int NSAMP = 1 << DEF_AVG_LOG2;

  // Accumulator must hold NSAMP samples of CNT_W bits.
  function automatic int acc_width(
    input int cnt_w,
    input int avg_log2
  );
    return cnt_w + avg_log2;
  endfunction

  function automatic int nsamp_of(
    input int avg_log2
  );
    return 1 << avg_log2;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with rising-edge pulse.
// Ports: clk_i, rstn_i, async_i (async input), rise_o (1-cycle pulse).
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   dly_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    dly_d  = sync_s;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise_o = sync_s & ~dly_q;

endmodule

// File: rtl/period_meter.sv
// Averaged period meter for a slow clock-like input.
// Ports: clk_i, rstn_i, en_i, sig_i in; period_o/valid_o/ready_i result
// handshake; ovf_o (timeout, sticky), overrun_o (lost result, sticky).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC,
  parameter int AVG_LOG2    = DEF_AVG_LOG2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             ovf_o,
  output logic             overrun_o
);

  localparam int AccW = acc_width(CNT_W, AVG_LOG2);
  localparam int NsW  = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntLast =
    CntMax - CNT_W'(1);
  localparam logic [NsW-1:0]   NsLast  =
    NsW'(nsamp_of(AVG_LOG2) - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [AccW-1:0]  acc_q;
  logic [AccW-1:0]  acc_d;
  logic [NsW-1:0]   nsamp_q;
  logic [NsW-1:0]   nsamp_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic             valid_q;
  logic             valid_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             overrun_q;
  logic             overrun_d;

  logic             rise;
  logic [CNT_W-1:0] sample;
  logic [AccW-1:0]  sum;
  logic [CNT_W-1:0] avg;
  logic             timeout;
  logic             load;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .async_i(sig_i),
    .rise_o (rise)
  );

  assign sample  = cnt_q + CNT_W'(1);
  assign sum     = acc_q + AccW'(sample);
  assign avg     = CNT_W'(sum >> AVG_LOG2);
  // A sample of CntMax cannot be told from a
  // stuck input, so it is treated as a timeout.
  assign timeout = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    nsamp_d   = nsamp_q;
    period_d  = period_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;
    load      = 1'b0;

    if (!en_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      acc_d     = '0;
      nsamp_d   = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          acc_d   = '0;
          nsamp_d = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = '0;
            acc_d   = '0;
            nsamp_d = '0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (timeout) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            nsamp_d = '0;
            state_d = ARM;
          end else if (rise) begin
            // This rise also opens the next period.
            cnt_d = '0;
            if (nsamp_q == NsLast) begin
              load    = 1'b1;
              acc_d   = '0;
              nsamp_d = '0;
            end else begin
              acc_d   = sum;
              nsamp_d = nsamp_q + NsW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // A load in the transfer cycle is not
      // an overrun: the old value was taken.
      if (load) begin
        period_d = avg;
        valid_d  = 1'b1;
        ovf_d    = 1'b0;
        if (valid_q && !ready_i) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      nsamp_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      nsamp_q   <= nsamp_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign ovf_o     = ovf_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter (CNT_W=8, AVG_LOG2=2).
// Expected results are queued by stimulus and popped on transfer.
`timescale 1ns/1ns
module tb_period_meter;
  import period_meter_pkg::*;

  logic       clk;
  logic       rstn_i;
  logic       en_i;
  logic       sig_i;
  logic [7:0] period_o;
  logic       valid_o;
  logic       ready_i;
  logic       ovf_o;
  logic       overrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];
  int xq[$];
  int gaps[$];

  period_meter #(
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .AVG_LOG2   (2)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .en_i     (en_i),
    .sig_i    (sig_i),
    .period_o (period_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .ovf_o    (ovf_o),
    .overrun_o(overrun_o)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Rise now, then one rise per gap entry.
  task automatic run_gaps();
    sig_i = 1'b1;
    foreach (gaps[i]) begin
      tick(gaps[i] / 2);
      sig_i = 1'b0;
      tick(gaps[i] - gaps[i] / 2);
      sig_i = 1'b1;
    end
    tick(2);
    sig_i = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rstn_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected: got %0d want none",
                   period_o);
        end else begin
          chk("result", int'(period_o),
              exp_q.pop_front());
        end
        xq.push_back(cyc);
      end
    end
  end

  initial begin
    rstn_i  = 1'b0;
    en_i    = 1'b0;
    sig_i   = 1'b0;
    ready_i = 1'b1;
    #3;
    chk("rst period", int'(period_o), 0);
    chk("rst valid", int'(valid_o), 0);
    chk("rst ovf", int'(ovf_o), 0);
    chk("rst overrun", int'(overrun_o), 0);
    #2;
    rstn_i = 1'b1;
    tick(1);

    // idle with sig toggling
    repeat (67) begin
      sig_i = ~sig_i;
      tick(3);
    end
    chk("idle state", int'(dut.state_q), int'(IDLE));
    chk("idle valid", int'(valid_o), 0);
    chk("idle period", int'(period_o), 0);
    sig_i = 1'b0;
    tick(4);

    // constant period 4
    en_i = 1'b1;
    tick(3);
    xq.delete();
    gaps = '{4, 4, 4, 4, 4, 4, 4, 4};
    exp_q.push_back(4);
    exp_q.push_back(4);
    run_gaps();
    tick(10);
    chk("const xfers", xq.size(), 2);
    if (xq.size() == 2)
      chk("const spacing", xq[1] - xq[0], 16);
    en_i = 1'b0;
    tick(3);

    // averaging, truncation, min period
    en_i = 1'b1;
    tick(3);
    xq.delete();
    gaps = '{4, 4, 4, 5, 3, 5, 3, 5,
             2, 2, 2, 3, 7, 7, 7, 7};
    exp_q.push_back(4);
    exp_q.push_back(4);
    exp_q.push_back(2);
    exp_q.push_back(7);
    run_gaps();
    tick(10);
    chk("avg xfers", xq.size(), 4);
    en_i = 1'b0;
    tick(3);

    // timeout then restart
    en_i = 1'b1;
    tick(3);
    gaps = '{5};
    run_gaps();
    tick(200);
    chk("ovf early", int'(ovf_o), 0);
    tick(100);
    chk("ovf set", int'(ovf_o), 1);
    chk("ovf state", int'(dut.state_q), int'(ARM));
    gaps = '{6, 6, 6, 6};
    exp_q.push_back(6);
    run_gaps();
    tick(8);
    chk("ovf cleared", int'(ovf_o), 0);
    chk("restart period", int'(period_o), 6);
    en_i = 1'b0;
    tick(3);

    // backpressure across two windows
    en_i = 1'b1;
    tick(3);
    ready_i = 1'b0;
    gaps = '{4, 4, 4, 4, 6, 6, 6, 6};
    exp_q.push_back(6);
    run_gaps();
    tick(6);
    chk("bp valid", int'(valid_o), 1);
    chk("bp period", int'(period_o), 6);
    chk("bp overrun", int'(overrun_o), 1);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    #1;
    chk("bp valid drop", int'(valid_o), 0);
    chk("bp overrun sticky", int'(overrun_o), 1);
    tick(1);
    ready_i = 1'b1;

    // disable mid-window
    gaps = '{3, 3};
    run_gaps();
    en_i = 1'b0;
    tick(1);
    chk("dis state", int'(dut.state_q), int'(IDLE));
    chk("dis valid", int'(valid_o), 0);
    chk("dis overrun", int'(overrun_o), 0);
    chk("dis period kept", int'(period_o), 6);
    en_i = 1'b1;
    tick(3);
    gaps = '{7, 7, 7, 7};
    exp_q.push_back(7);
    run_gaps();
    tick(8);

    // async reset mid-window
    gaps = '{5, 5};
    run_gaps();
    chk("pre-rst period", int'(period_o), 7);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst period", int'(period_o), 0);
    chk("arst valid", int'(valid_o), 0);
    chk("arst state", int'(dut.state_q), int'(IDLE));
    tick(1);
    rstn_i = 1'b1;
    tick(3);
    gaps = '{4, 4, 4, 4};
    exp_q.push_back(4);
    run_gaps();
    tick(8);

    chk("pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
